// File: rtl/bcd_subtractor_serial_pkg.sv
// Shared types and constants for the digit-serial BCD subtractor.
package bcd_subtractor_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int BCD_BASE      = 10;
   localparam int BCD_MAX_DIGIT = 9;

   function automatic logic digit_ok(input logic [3:0] dig);
      return dig <= 4'(BCD_MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_subtractor_serial_digit.sv
// Single BCD digit subtract with borrow: d = a - b - borrow_in, folded into 0..9.
module bcd_digit_sub
   import bcd_subtractor_serial_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       borrow_in,
   output logic [3:0] d,
   output logic       borrow_out
);

   // 5-bit two's complement covers -16..15 even for out-of-range digits
   logic [4:0] t;

   always_comb begin
      t          = {1'b0, a} - {1'b0, b} - {4'b0000, borrow_in};
      borrow_out = t[4];
      d          = borrow_out ? (t[3:0] + 4'(BCD_BASE)) : t[3:0];
   end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor, one digit per clock, least significant first.
// Optional invalid-digit flag (err port) is built when BCD_CHECK_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; operands captured when start is seen
// SUB     | one digit per cycle, digit 0 first, DIGITS cycles in total
// DONE    | single cycle, done=1, D/BorrowOut (and err) just updated
module bcd_subtractor_serial
   import bcd_subtractor_serial_pkg::*;
#(
   parameter int DIGITS = 2
)(
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   A,
   input  logic [4*DIGITS-1:0]   B,
   input  logic                  BorrowIn,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   D,
   output logic                  BorrowOut
`ifdef BCD_CHECK_EN
   ,
   output logic                  err
`endif
);

   localparam int W = 4 * DIGITS;

   state_t         state, state_nxt;
   logic [W-1:0]   a_reg, b_reg, d_acc, d_final;
   logic           borrow, borrow_nxt;
   logic [3:0]     idx;
   logic [3:0]     a_dig, b_dig, d_dig;
   logic           last_dig;

   always_comb begin
      a_dig = '0;
      b_dig = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == 4'(i)) begin
            a_dig = a_reg[4*i +: 4];
            b_dig = b_reg[4*i +: 4];
         end
      end
   end

   bcd_digit_sub u_digit (
      .a          (a_dig),
      .b          (b_dig),
      .borrow_in  (borrow),
      .d          (d_dig),
      .borrow_out (borrow_nxt)
   );

   // partial result with the current digit merged in, so the last digit lands in D directly
   always_comb begin
      d_final = d_acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == 4'(i)) d_final[4*i +: 4] = d_dig;
      end
   end

   assign last_dig = (idx == 4'(DIGITS - 1));

`ifdef BCD_CHECK_EN
   logic any_bad;

   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!digit_ok(a_reg[4*i +: 4]) || !digit_ok(b_reg[4*i +: 4])) any_bad = 1'b1;
      end
   end
`endif

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SUB;
         ST_SUB:  if (last_dig) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         a_reg     <= '0;
         b_reg     <= '0;
         d_acc     <= '0;
         borrow    <= 1'b0;
         idx       <= '0;
         D         <= '0;
         BorrowOut <= 1'b0;
`ifdef BCD_CHECK_EN
         err       <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_reg  <= A;
                  b_reg  <= B;
                  borrow <= BorrowIn;
                  idx    <= '0;
                  d_acc  <= '0;
`ifdef BCD_CHECK_EN
                  err    <= 1'b0;
`endif
               end
            end
            ST_SUB: begin
               d_acc  <= d_final;
               borrow <= borrow_nxt;
               idx    <= idx + 4'd1;
               if (last_dig) begin
`ifdef BCD_CHECK_EN
                  if (any_bad) begin
                     D         <= '0;
                     BorrowOut <= 1'b0;
                     err       <= 1'b1;
                  end else begin
                     D         <= d_final;
                     BorrowOut <= borrow_nxt;
                  end
`else
                  D         <= d_final;
                  BorrowOut <= borrow_nxt;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Directed self-checking bench for bcd_subtractor_serial (DIGITS=2); err checks need BCD_CHECK_EN.
module tb_bcd_subtractor_serial;

   logic       CLK = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] A, B;
   logic       BorrowIn;
   logic       busy, done;
   logic [7:0] D;
   logic       BorrowOut;
`ifdef BCD_CHECK_EN
   logic       err;
`endif

   int checks = 0;
   int failures = 0;

   bcd_subtractor_serial #(.DIGITS(2)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .start     (start),
      .A         (A),
      .B         (B),
      .BorrowIn  (BorrowIn),
      .busy      (busy),
      .done      (done),
      .D         (D),
      .BorrowOut (BorrowOut)
`ifdef BCD_CHECK_EN
      ,
      .err       (err)
`endif
   );

   always #5 CLK = ~CLK;

   initial begin
      #1500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] hi, lo;
      hi = 4'(v / 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   // returns D/BorrowOut seen in the DONE cycle and rising edges from start to done
   task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output int lat);
      @(negedge CLK);
      A = a; B = b; BorrowIn = bin; start = 1'b1;
      lat = 0;
      d = 8'h00; bo = 1'b0;
      do begin
         @(posedge CLK); #1;
         lat++;
         if (lat == 1) start = 1'b0;
      end while (!done && lat < 20);
      d = D; bo = BorrowOut;
      @(posedge CLK); #1;
   endtask

   logic [7:0] d;
   logic       bo;
   int         lat, pulses, n, t0, t1, g;
   int         av, bv, bin, exp_v;
   logic       exp_bo;

   initial begin
      reset = 1'b1; start = 1'b0; A = '0; B = '0; BorrowIn = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_d", int'(D), 0);
      chk("rst_bo", int'(BorrowOut), 0);
`ifdef BCD_CHECK_EN
      chk("rst_err", int'(err), 0);
`endif
      @(negedge CLK) reset = 1'b0;

      do_op(8'h45, 8'h12, 1'b0, d, bo, lat);
      chk("45-12_d", int'(d), 'h33);
      chk("45-12_bo", int'(bo), 0);
      chk("45-12_latency", lat, 3);
      chk("hold_after_done", int'(D), 'h33);

      do_op(8'h12, 8'h45, 1'b0, d, bo, lat);
      chk("12-45_d", int'(d), 'h67);
      chk("12-45_bo", int'(bo), 1);

      do_op(8'h99, 8'h99, 1'b0, d, bo, lat);
      chk("99-99_d", int'(d), 'h00);
      chk("99-99_bo", int'(bo), 0);

      do_op(8'h99, 8'h00, 1'b1, d, bo, lat);
      chk("99-00-1_d", int'(d), 'h98);
      chk("99-00-1_bo", int'(bo), 0);

      do_op(8'h50, 8'h49, 1'b1, d, bo, lat);
      chk("50-49-1_d", int'(d), 'h00);
      chk("50-49-1_bo", int'(bo), 0);

      do_op(8'h00, 8'h00, 1'b1, d, bo, lat);
      chk("00-00-1_d", int'(d), 'h99);
      chk("00-00-1_bo", int'(bo), 1);

      // start during busy must be ignored
      @(negedge CLK);
      A = 8'h50; B = 8'h25; BorrowIn = 1'b0; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk("busy_after_start", int'(busy), 1);
      chk("d_held_while_busy", int'(D), 'h99);
      @(negedge CLK);
      A = 8'h99; B = 8'h01; start = 1'b1;
      @(negedge CLK);
      start = 1'b0; A = '0; B = '0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge CLK); #1;
         if (done) pulses++;
      end
      chk("ignore_start_d", int'(D), 'h25);
      chk("ignore_start_bo", int'(BorrowOut), 0);
      chk("ignore_start_pulses", pulses, 1);
      chk("ignore_start_idle", int'(busy), 0);

      // reset one cycle after start aborts with no done
      @(negedge CLK);
      A = 8'h33; B = 8'h11; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      @(posedge CLK); #1;
      reset = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_d", int'(D), 0);
      chk("abort_bo", int'(BorrowOut), 0);
      @(negedge CLK) reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK); #1;
         if (done) pulses++;
      end
      chk("abort_no_done", pulses, 0);
      do_op(8'h90, 8'h09, 1'b0, d, bo, lat);
      chk("after_abort_d", int'(d), 'h81);
      chk("after_abort_bo", int'(bo), 0);
      chk("after_abort_latency", lat, 3);

      // start held high restarts every DIGITS+2 cycles
      @(negedge CLK);
      A = 8'h45; B = 8'h12; BorrowIn = 1'b0; start = 1'b1;
      n = 0; t0 = 0; t1 = 0;
      for (int i = 0; i < 14; i++) begin
         @(posedge CLK); #1;
         if (done) begin
            if (n == 0) t0 = i;
            else if (n == 1) t1 = i;
            n++;
         end
      end
      @(negedge CLK) start = 1'b0;
      chk("held_start_count", int'(n >= 2), 1);
      chk("held_start_period", t1 - t0, 4);
      chk("held_start_d", int'(D), 'h33);
      g = 0;
      while (busy && g < 10) begin
         @(posedge CLK); #1;
         g++;
      end
      chk("drain_idle", int'(busy), 0);

`ifdef BCD_CHECK_EN
      do_op(8'h1A, 8'h01, 1'b0, d, bo, lat);
      chk("bad_digit_d", int'(d), 0);
      chk("bad_digit_bo", int'(bo), 0);
      chk("bad_digit_err", int'(err), 1);
      chk("bad_digit_latency", lat, 3);
      do_op(8'h10, 8'h01, 1'b0, d, bo, lat);
      chk("good_after_bad_d", int'(d), 'h09);
      chk("good_after_bad_err", int'(err), 0);
`endif

      // full sweep of valid operands, borrow-in alternated over the grid
      for (int a = 0; a < 100; a++) begin
         for (int b = 0; b < 100; b++) begin
            av = a; bv = b; bin = (a + b) % 2;
            exp_v = av - bv - bin;
            exp_bo = (exp_v < 0);
            if (exp_v < 0) exp_v = exp_v + 100;
            do_op(to_bcd(av), to_bcd(bv), bin[0], d, bo, lat);
            chk($sformatf("sweep_%0d_%0d_%0d", av, bv, bin),
                int'({bo, d}), int'({exp_bo, to_bcd(exp_v)}));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
